// File: rtl/div_issue_stage_pkg.sv
// Shared definitions for the divider issue stage.
//   DIV_A_W / DIV_B_W : dividend and divisor widths of the datapath
//   DIV_DBZ_QUOT      : quotient reported when the divisor is zero
//   DIV_TAG_MAX_W     : storage width reserved for the opaque tag; the
//                       top-level TAG_W must not exceed it
//   div_req_t         : one queued operation {a, b, tag}
package div_issue_stage_pkg;

    localparam int DIV_A_W       = 16;
    localparam int DIV_B_W       = 8;
    localparam int DIV_TAG_MAX_W = 16;

    localparam logic [DIV_A_W-1:0] DIV_DBZ_QUOT = 16'hFFFF;

    typedef struct packed {
        logic [DIV_A_W-1:0]       a;
        logic [DIV_B_W-1:0]       b;
        logic [DIV_TAG_MAX_W-1:0] tag;
    } div_req_t;

endpackage

// File: rtl/div_16bit.sv
// Combinational 16-by-8 unsigned divider.
//   A      : dividend
//   B      : divisor
//   result : quotient A/B (DIV_DBZ_QUOT when B is zero)
//   odd    : remainder A%B, zero-extended to 16 bits (zero when B is zero)
module div_16bit
    import div_issue_stage_pkg::*;
(
    input  logic [DIV_A_W-1:0] A,
    input  logic [DIV_B_W-1:0] B,
    output logic [DIV_A_W-1:0] result,
    output logic [DIV_A_W-1:0] odd
);

    // One extra bit so the shifted partial remainder (< 2*B) never overflows.
    logic [DIV_B_W:0]   partial;
    logic [DIV_A_W-1:0] quot;

    // Restoring long division, one dividend bit per unrolled step, MSB first.
    always_comb begin
        partial = '0;
        quot    = '0;
        for (int i = DIV_A_W - 1; i >= 0; i--) begin
            partial = {partial[DIV_B_W-1:0], A[i]};
            if (partial >= {1'b0, B}) begin
                partial = partial - {1'b0, B};
                quot[i] = 1'b1;
            end
        end
    end

    // A zero divisor would leave the dividend in the partial remainder, so
    // the divide-by-zero results are forced explicitly.
    assign result = (B == '0) ? DIV_DBZ_QUOT : quot;
    assign odd    = (B == '0) ? '0
                              : {{(DIV_A_W - DIV_B_W){1'b0}}, partial[DIV_B_W-1:0]};

endmodule

// File: rtl/div_operand_fifo.sv
// Synchronous FIFO of div_req_t entries.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous empty, takes priority over push and pop
//   push       : write wr_data (ignored when full)
//   pop        : discard the head entry (ignored when empty)
//   rd_data    : current head entry, only meaningful when count > 0
//   count      : occupancy, 0..DEPTH
module div_operand_fifo
    import div_issue_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  div_req_t               wr_data,
    output div_req_t               rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    div_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !clear && (count != FULL_COUNT);
    assign do_pop  = pop  && !clear && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow and
    // count is what tells a full FIFO from an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_issue_stage.sv
// Issue stage around the combinational divider: operand FIFO in front,
// registered result stage with valid/ready behind.
//   clk, rst_n          : clock and asynchronous active-low reset
//   flush               : synchronous clear of FIFO and output stage
//   in_valid/in_ready   : operand handshake (in_a dividend, in_b divisor,
//                         in_tag returned with the result)
//   out_valid/out_ready : result handshake
//   out_quot, out_rem   : quotient and zero-extended remainder
//   out_dbz             : divisor was zero (quotient all ones, remainder 0)
//   out_tag             : tag of the operation
//   count               : operand FIFO occupancy
module div_issue_stage
    import div_issue_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIV_A_W-1:0]     in_a,
    input  logic [DIV_B_W-1:0]     in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIV_A_W-1:0]     out_quot,
    output logic [DIV_A_W-1:0]     out_rem,
    output logic                   out_dbz,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    div_req_t           in_req;
    div_req_t           head;
    logic               push;
    logic               load;
    logic [DIV_A_W-1:0] div_quot;
    logic [DIV_A_W-1:0] div_rem;
    logic               tag_pad_unused;

    // No bypass: a full FIFO refuses input even if the head is leaving.
    assign in_ready = (count != FULL_COUNT);
    assign push     = in_valid && in_ready && !flush;

    // The head moves into the output register whenever that register is
    // empty or being drained this cycle, giving one result per cycle.
    assign load = (count != '0) && (!out_valid || out_ready);

    assign in_req.a   = in_a;
    assign in_req.b   = in_b;
    assign in_req.tag = DIV_TAG_MAX_W'(in_tag);

    // Tag storage is wider than TAG_W; the padding bits are never read back.
    assign tag_pad_unused = ^head.tag;

    div_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .push    (push),
        .pop     (load),
        .wr_data (in_req),
        .rd_data (head),
        .count   (count)
    );

    div_16bit u_div (
        .A      (head.a),
        .B      (head.b),
        .result (div_quot),
        .odd    (div_rem)
    );

    // Output register: flush wins, then a load, then a plain drain. Data is
    // only written on a load, so it holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_rem   <= '0;
            out_dbz   <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_quot  <= div_quot;
            out_rem   <= div_rem;
            out_dbz   <= (head.b == '0);
            out_tag   <= head.tag[TAG_W-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_issue_stage.sv
// Self-checking bench for div_issue_stage: directed cases from the test plan
// plus a randomized run, all checked against a queue-based reference model.
module tb_div_issue_stage;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [7:0]       in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_quot;
    logic [15:0]      out_rem;
    logic             out_dbz;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    div_issue_stage #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .out_dbz   (out_dbz),
        .out_tag   (out_tag),
        .count     (count)
    );

    // Reference model: a queue of pending operations plus one result slot.
    typedef struct {
        logic [15:0]      a;
        logic [7:0]       b;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t              model_q[$];
    logic             m_valid;
    logic [15:0]      m_quot;
    logic [15:0]      m_rem;
    logic             m_dbz;
    logic [TAG_W-1:0] m_tag;

    int checks = 0;
    int errors = 0;
    bit acc;

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        m_valid = 1'b0;
        m_quot  = '0;
        m_rem   = '0;
        m_dbz   = 1'b0;
        m_tag   = '0;
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, then
    // compare every output just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [7:0] b,
                                 input logic [TAG_W-1:0] tag, input logic rdy,
                                 input logic fl, output bit accepted);
        op_t op;
        bit  do_load;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
        checkOutput("in_ready", in_ready, model_q.size() < DEPTH);
        accepted = v && (model_q.size() < DEPTH) && !fl;
        do_load  = (model_q.size() > 0) && (!m_valid || rdy);
        if (fl) begin
            model_q.delete();
            m_valid = 1'b0;
        end else begin
            if (do_load) begin
                op      = model_q.pop_front();
                m_valid = 1'b1;
                m_tag   = op.tag;
                if (op.b == 0) begin
                    m_quot = 16'hFFFF;
                    m_rem  = 16'h0;
                    m_dbz  = 1'b1;
                end else begin
                    m_quot = op.a / op.b;
                    m_rem  = op.a % op.b;
                    m_dbz  = 1'b0;
                end
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            if (accepted) begin
                op.a   = a;
                op.b   = b;
                op.tag = tag;
                model_q.push_back(op);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", out_valid, m_valid);
        checkOutput("count", count, model_q.size());
        checkOutput("out_quot", out_quot, m_quot);
        checkOutput("out_rem", out_rem, m_rem);
        checkOutput("out_dbz", out_dbz, m_dbz);
        checkOutput("out_tag", out_tag, m_tag);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b1, 1'b0, acc);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_quot", out_quot, 0);
        checkOutput("reset_rem", out_rem, 0);
        checkOutput("reset_dbz", out_dbz, 0);
        checkOutput("reset_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", in_ready, 1);

        // Single op: result visible one edge after the push edge.
        applyStimulus(1'b1, 16'd1000, 8'd7, 4'd3, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 16'd0, 8'd0, 4'd0, 1'b1, 1'b0, acc);
        checkOutput("single_valid", out_valid, 1);
        checkOutput("single_quot", out_quot, 142);
        checkOutput("single_rem", out_rem, 6);
        checkOutput("single_dbz", out_dbz, 0);
        checkOutput("single_tag", out_tag, 3);
        idleCycles(2);

        // Boundary operands, back to back.
        applyStimulus(1'b1, 16'd65535, 8'd255, 4'd1, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 16'd5, 8'd9, 4'd2, 1'b1, 1'b0, acc);
        checkOutput("max_quot", out_quot, 257);
        checkOutput("max_rem", out_rem, 0);
        applyStimulus(1'b0, 16'd0, 8'd0, 4'd0, 1'b1, 1'b0, acc);
        checkOutput("small_quot", out_quot, 0);
        checkOutput("small_rem", out_rem, 5);
        idleCycles(2);

        // Divide by zero followed immediately by a normal op.
        applyStimulus(1'b1, 16'd1234, 8'd0, 4'd4, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 16'd20, 8'd3, 4'd5, 1'b1, 1'b0, acc);
        checkOutput("dbz_quot", out_quot, 16'hFFFF);
        checkOutput("dbz_rem", out_rem, 0);
        checkOutput("dbz_flag", out_dbz, 1);
        applyStimulus(1'b0, 16'd0, 8'd0, 4'd0, 1'b1, 1'b0, acc);
        checkOutput("after_dbz_valid", out_valid, 1);
        checkOutput("after_dbz_quot", out_quot, 6);
        checkOutput("after_dbz_rem", out_rem, 2);
        checkOutput("after_dbz_flag", out_dbz, 0);
        idleCycles(2);

        // Backpressure: fill while stalled, then release and wrap pointers.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'(100 * (i + 1) + 7), 8'(i + 2), 4'(i), 1'b0, 1'b0, acc);
        end
        checkOutput("bp_count_full", count, 4);
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_hold_tag", out_tag, 0);
        checkOutput("bp_hold_quot", out_quot, 107 / 2);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 16'd607, 8'd7, 4'd5, 1'b0, 1'b0, acc);
        end
        checkOutput("bp_op5_held_count", count, 4);
        checkOutput("bp_op5_held_tag", out_tag, 0);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            applyStimulus(1'b1, 16'd607, 8'd7, 4'd5, 1'b1, 1'b0, acc);
            if (i == 0) begin
                checkOutput("bp_release_tag", out_tag, 1);
            end
        end
        checkOutput("bp_op5_accepted", acc, 1);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            applyStimulus(1'b1, 16'($urandom), 8'($urandom_range(1, 255)), 4'(i + 6),
                          1'b1, 1'b0, acc);
        end
        idleCycles(DEPTH + 2);

        // Flush with three ops queued and a result pending.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'(50 + i), 8'd3, 4'(i + 8), 1'b0, 1'b0, acc);
        end
        checkOutput("pre_flush_count", count, 3);
        checkOutput("pre_flush_valid", out_valid, 1);
        applyStimulus(1'b1, 16'd999, 8'd9, 4'd15, 1'b0, 1'b1, acc);
        checkOutput("flush_count", count, 0);
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_in_ready", in_ready, 1);
        applyStimulus(1'b1, 16'd77, 8'd7, 4'd9, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 16'd0, 8'd0, 4'd0, 1'b1, 1'b0, acc);
        checkOutput("post_flush_quot", out_quot, 11);
        checkOutput("post_flush_rem", out_rem, 0);
        checkOutput("post_flush_tag", out_tag, 9);
        idleCycles(2);

        // Randomized traffic with occasional zero divisors and flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom),
                          ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
                          4'($urandom), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 31) == 0, acc);
        end
        idleCycles(DEPTH + 2);

        // Asynchronous reset with two ops queued behind a pending result.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'(300 + i), 8'd4, 4'(i + 1), 1'b0, 1'b0, acc);
        end
        checkOutput("pre_reset_count", count, 2);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", out_valid, 0);
        checkOutput("async_reset_count", count, 0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", in_ready, 1);
        idleCycles(4);
        checkOutput("post_reset_no_stale", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_stage.md
Name: div_issue_stage

Overview:
Sequential front/back end wrapped around the combinational 16-by-8 divider datapath (div_16bit: A, B in; result, odd out). It buffers operand pairs from a valid/ready producer in a small FIFO and presents the FIFO head to the divider. It registers the quotient, remainder and a divide-by-zero flag into an output stage with valid/ready toward the consumer. This stage decouples the arithmetic pipeline from bursty producers and stalling consumers.

Parameters:
DEPTH, 4, operand FIFO entries; must be a power of 2, >= 2
TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO and output stage
in_valid  input  1  operand pair valid
in_ready  output  1  stage can accept an operand pair
in_a  input  16  dividend
in_b  input  8  divisor
in_tag  input  TAG_W  tag returned with the result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_quot  output  16  quotient, A/B
out_rem  output  16  remainder, A%B, zero-extended
out_dbz  output  1  divisor was zero
out_tag  output  TAG_W  tag of this result
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers and count = 0; out_valid = 0; out_quot, out_rem, out_tag = 0; out_dbz = 0. in_ready reads 1 as soon as rst_n is high.
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b, in_tag} at the write pointer. in_ready = (count < DEPTH); there is no bypass when full.
- Head: when count > 0, the FIFO head drives the divider combinationally.
- Pop/load: load = (count > 0) && (!out_valid || out_ready). On load:
  - out_quot <= divider result; out_rem <= divider odd; out_tag <= head tag.
  - out_dbz <= (head B == 0).
  - out_valid <= 1; the FIFO pops.
- Output drain: out_valid && out_ready && !load clears out_valid. Output data holds its last value.
- Divide by zero: quotient 16'hFFFF, remainder 0, out_dbz 1. It is not an error stall; the stage proceeds normally.
- Latency: a push at edge N into an empty stage with an idle output gives out_valid high after edge N+1. Sustained throughput is 1 result per cycle when out_ready is held high.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. When count == DEPTH, push is impossible and pop still proceeds.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Output stability: while out_valid && !out_ready, out_quot, out_rem, out_dbz and out_tag hold stable.
- flush (synchronous) has priority over push and pop in the same cycle. It empties the FIFO, drops out_valid and discards any accepted input that cycle. in_ready follows count and is therefore 1 in the next cycle.
- Reset mid-operation discards all in-flight entries. No result is emitted for them.

Decomposition:
- Shared package: DIV_A_W = 16, DIV_B_W = 8, DIV_DBZ_QUOT = 16'hFFFF, and a packed struct div_req_t {a, b, tag}.
- Sub-module div_operand_fifo: generic synchronous FIFO of div_req_t with push/pop/count, same clock and reset.
- The existing div_16bit is instantiated as the datapath.

Test Plan:
- Single op: push A=1000, B=7, tag=3 with out_ready=1 -> one cycle later out_valid=1, quot=142, rem=6, dbz=0, tag=3.
- Boundary: push A=65535, B=255 -> quot=257, rem=0. Then push A=5, B=9 -> quot=0, rem=5.
- Divide by zero: push A=1234, B=0 -> quot=16'hFFFF, rem=0, dbz=1. The following op A=20, B=3 -> quot=6, rem=2 with no stall.
- Backpressure:
  - Setup: out_ready=0, push 5 ops back-to-back.
  - While stalled: the output holds op0; ops 1-4 fill the FIFO, count=4, in_ready=0; op5 stays held on the input.
  - After out_ready=1: results appear in order op0..op5, one per cycle.
  - Wrap check: continue for 2*DEPTH ops to exercise pointer wrap.
- Flush:
  - Setup: with 3 ops queued and out_valid=1, assert flush together with in_valid.
  - Required response: next cycle count=0, out_valid=0, and the concurrent input is dropped.
  - A new op after flush returns the correct result.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with 2 ops queued -> out_valid and count are 0 immediately. After release, no stale results appear and in_ready=1.
